// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back selection, HALT retirement
// detection and a saturating retired-instruction counter for the debug unit.
module mem_wb_stage #(
  parameter int unsigned BITS_SIZE  = 32,
  parameter int unsigned BITS_REG   = 5,
  parameter int unsigned BITS_COUNT = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_step,
  input  logic [BITS_SIZE-1:0]  i_mem_dato,
  input  logic [BITS_SIZE-1:0]  i_exmem_alu,
  input  logic [BITS_SIZE-1:0]  i_exmem_pc8,
  input  logic [BITS_REG-1:0]   i_exmem_rd,
  input  logic                  i_exmem_valid,
  input  logic                  i_exmem_reg_write,
  input  logic                  i_exmem_mem_to_reg,
  input  logic                  i_exmem_link,
  input  logic                  i_exmem_halt,
  output logic                  o_memwb_reg_write,
  output logic [BITS_REG-1:0]   o_memwb_rd,
  output logic [BITS_SIZE-1:0]  o_memwb_wb_data,
  output logic                  o_halted,
  output logic [BITS_COUNT-1:0] o_retired_count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    reg_write_q, reg_write_d;
  logic [BITS_REG-1:0]     rd_q, rd_d;
  logic [BITS_SIZE-1:0]    wb_data_q, wb_data_d;
  logic [BITS_COUNT-1:0]   count_q, count_d;
  logic                    capture;
  logic [BITS_SIZE-1:0]    wb_sel;

  // Next-state and next-output logic; HALTED only leaves through reset.
  always_comb begin
    state_d     = state_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    wb_data_d   = wb_data_q;
    count_d     = count_q;
    capture     = 1'b0;
    wb_sel      = i_exmem_alu;

    if (i_exmem_link) begin
      wb_sel = i_exmem_pc8;
    end else if (i_exmem_mem_to_reg) begin
      wb_sel = i_mem_dato;
    end

    case (state_q)
      ST_RUN: begin
        capture = i_step;
      end
      ST_HALTED: begin
        reg_write_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (capture) begin
      wb_data_d   = wb_sel;
      rd_d        = i_exmem_rd;
      reg_write_d = i_exmem_valid & i_exmem_reg_write &
                    (i_exmem_rd != '0) & ~i_exmem_halt;
      if (i_exmem_valid && !(&count_q)) begin
        count_d = count_q + BITS_COUNT'(1);
      end
      if (i_exmem_valid && i_exmem_halt) begin
        state_d = ST_HALTED;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= ST_RUN;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wb_data_q   <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wb_data_q   <= wb_data_d;
      count_q     <= count_d;
    end
  end

  assign o_memwb_reg_write = reg_write_q;
  assign o_memwb_rd        = rd_q;
  assign o_memwb_wb_data   = wb_data_q;
  assign o_halted          = (state_q == ST_HALTED);
  assign o_retired_count   = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table plus reset, halt and
// counter-saturation sequences.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        step;
  logic [31:0] mem_dato, alu, pc8;
  logic [4:0]  rd;
  logic        valid, rw, m2r, link, halt;

  logic        o_rw, s_rw;
  logic [4:0]  o_rd, s_rd;
  logic [31:0] o_wb, s_wb;
  logic        o_halted, s_halted;
  logic [31:0] o_cnt;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .i_clk(clk), .i_reset(rst_n), .i_step(step),
    .i_mem_dato(mem_dato), .i_exmem_alu(alu), .i_exmem_pc8(pc8),
    .i_exmem_rd(rd), .i_exmem_valid(valid), .i_exmem_reg_write(rw),
    .i_exmem_mem_to_reg(m2r), .i_exmem_link(link), .i_exmem_halt(halt),
    .o_memwb_reg_write(o_rw), .o_memwb_rd(o_rd), .o_memwb_wb_data(o_wb),
    .o_halted(o_halted), .o_retired_count(o_cnt)
  );

  mem_wb_stage #(.BITS_COUNT(4)) dut_sat (
    .i_clk(clk), .i_reset(rst_n), .i_step(step),
    .i_mem_dato(mem_dato), .i_exmem_alu(alu), .i_exmem_pc8(pc8),
    .i_exmem_rd(rd), .i_exmem_valid(valid), .i_exmem_reg_write(rw),
    .i_exmem_mem_to_reg(m2r), .i_exmem_link(link), .i_exmem_halt(halt),
    .o_memwb_reg_write(s_rw), .o_memwb_rd(s_rd), .o_memwb_wb_data(s_wb),
    .o_halted(s_halted), .o_retired_count(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        step, valid, rw, m2r, link, halt;
    logic [4:0]  rd;
    logic [31:0] alu, dato, pc8;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_wb;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic w, input logic mr,
                       input logic lk, input logic h, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    @(negedge clk);
    step = s; valid = v; rw = w; m2r = mr; link = lk; halt = h;
    rd = r; alu = a; mem_dato = d; pc8 = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step = 1'b1; valid = 1'b1; rw = 1'b1; rd = 5'd9; alu = 32'h55;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    step = 1'b0; valid = 1'b0;
  endtask

  function automatic vec_t mk(logic s, logic v, logic w, logic mr, logic lk,
                              logic [4:0] r, logic [31:0] a, logic [31:0] d,
                              logic [31:0] p, logic erw, logic [4:0] erd,
                              logic [31:0] ewb, logic [31:0] ecnt);
    vec_t t;
    t.step = s; t.valid = v; t.rw = w; t.m2r = mr; t.link = lk; t.halt = 1'b0;
    t.rd = r; t.alu = a; t.dato = d; t.pc8 = p;
    t.e_rw = erw; t.e_rd = erd; t.e_wb = ewb; t.e_cnt = ecnt;
    return t;
  endfunction

  initial begin
    // Table rows assume a freshly reset DUT (count 0).
    vecs[0] = mk(1,1,1,0,0, 5'd5,  32'h0000_1234, 32'h0,         32'h0,    1, 5'd5,  32'h0000_1234, 1);
    vecs[1] = mk(1,1,1,1,1, 5'd7,  32'h0000_1111, 32'hDEAD_BEEF, 32'h40,   1, 5'd7,  32'h0000_0040, 2);
    vecs[2] = mk(1,1,1,1,0, 5'd7,  32'h0000_1111, 32'hDEAD_BEEF, 32'h40,   1, 5'd7,  32'hDEAD_BEEF, 3);
    vecs[3] = mk(1,0,1,0,0, 5'd9,  32'h0000_2222, 32'h0,         32'h0,    0, 5'd9,  32'h0000_2222, 3);
    vecs[4] = mk(1,1,1,0,0, 5'd0,  32'h0000_3333, 32'h0,         32'h0,    0, 5'd0,  32'h0000_3333, 4);
    vecs[5] = mk(1,1,0,0,0, 5'd3,  32'h0000_4444, 32'h0,         32'h0,    0, 5'd3,  32'h0000_4444, 5);
    vecs[6] = mk(0,1,1,0,0, 5'd12, 32'hAAAA_0001, 32'h0,         32'h0,    0, 5'd3,  32'h0000_4444, 5);
    vecs[7] = mk(0,1,1,1,0, 5'd13, 32'hAAAA_0002, 32'h1234_5678, 32'h0,    0, 5'd3,  32'h0000_4444, 5);
    vecs[8] = mk(0,1,1,0,1, 5'd14, 32'hAAAA_0003, 32'h0,         32'h88,   0, 5'd3,  32'h0000_4444, 5);
    vecs[9] = mk(1,1,1,0,0, 5'd31, 32'hFFFF_0000, 32'h0,         32'h0,    1, 5'd31, 32'hFFFF_0000, 6);

    rst_n = 1'b0; step = 1'b1; valid = 1'b0; rw = 1'b0; m2r = 1'b0; link = 1'b0;
    halt = 1'b0; rd = '0; alu = '0; mem_dato = '0; pc8 = '0;

    // Reset held two cycles with random inputs and step high.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      valid = 1'b1; rw = 1'b1; step = 1'b1;
      rd = 5'($urandom); alu = $urandom; mem_dato = $urandom; pc8 = $urandom;
      m2r = 1'($urandom); link = 1'($urandom); halt = 1'($urandom);
    end
    @(posedge clk);
    #1;
    chk("reset_rw", 32'(o_rw), 0);
    chk("reset_rd", 32'(o_rd), 0);
    chk("reset_wb", o_wb, 0);
    chk("reset_halted", 32'(o_halted), 0);
    chk("reset_cnt", o_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1; halt = 1'b0; step = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].step, vecs[i].valid, vecs[i].rw, vecs[i].m2r, vecs[i].link,
            vecs[i].halt, vecs[i].rd, vecs[i].alu, vecs[i].dato, vecs[i].pc8);
      chk($sformatf("vec%0d_rw", i),  32'(o_rw), 32'(vecs[i].e_rw));
      chk($sformatf("vec%0d_rd", i),  32'(o_rd), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d_wb", i),  o_wb, vecs[i].e_wb);
      chk($sformatf("vec%0d_cnt", i), o_cnt, vecs[i].e_cnt);
    end

    // Halt sequence: three ALU ops, HALT, then two more stepped instructions.
    do_reset();
    chk("rst_win_cnt", o_cnt, 0);
    chk("rst_win_rw", 32'(o_rw), 0);
    drive(1,1,1,0,0,0, 5'd1, 32'd10, 32'h0, 32'h0);
    drive(1,1,1,0,0,0, 5'd2, 32'd20, 32'h0, 32'h0);
    drive(1,1,1,0,0,0, 5'd3, 32'd30, 32'h0, 32'h0);
    chk("pre_halt_cnt", o_cnt, 3);
    drive(1,1,1,0,0,1, 5'd4, 32'd40, 32'h0, 32'h0);
    chk("halt_edge_halted", 32'(o_halted), 1);
    chk("halt_edge_rw", 32'(o_rw), 0);
    chk("halt_edge_cnt", o_cnt, 4);
    drive(1,1,1,0,0,0, 5'd6, 32'd60, 32'h0, 32'h0);
    drive(1,1,1,0,0,0, 5'd7, 32'd70, 32'h0, 32'h0);
    chk("halted_cnt", o_cnt, 4);
    chk("halted_flag", 32'(o_halted), 1);
    chk("halted_rw", 32'(o_rw), 0);
    chk("halted_rd", 32'(o_rd), 4);
    chk("halted_wb", o_wb, 40);
    do_reset();
    chk("unhalt_flag", 32'(o_halted), 0);
    chk("unhalt_cnt", o_cnt, 0);

    // Counter saturation on the 4-bit instance.
    for (int i = 0; i < 15; i++) begin
      drive(1,1,1,0,0,0, 5'(i + 1), 32'(i), 32'h0, 32'h0);
    end
    chk("sat_at_15", 32'(s_cnt), 32'hF);
    drive(1,1,1,0,0,0, 5'd20, 32'h16, 32'h0, 32'h0);
    drive(1,1,1,0,0,0, 5'd21, 32'h17, 32'h0, 32'h0);
    chk("sat_after_17", 32'(s_cnt), 32'hF);
    chk("sat_wb", s_wb, 32'h17);
    chk("wide_cnt_17", o_cnt, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and write-back selector for the five-stage MIPS core. Sits directly downstream of the MEM stage: it captures the load data returned by data memory together with the EX/MEM control and result fields, selects the value to be written to the register file, and presents it to the WB stage and the forwarding unit. It also detects retirement of the HALT instruction and keeps a retired-instruction counter for the debug unit.

## Interface
Parameters:
- BITS_SIZE, 32, datapath width
- BITS_REG, 5, register-index width
- BITS_COUNT, 32, retired-instruction counter width

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- i_clk  in  1  clock, all state updates on the rising edge
- i_reset  in  1  synchronous, active-low reset
- i_step  in  1  advance enable from the debug unit; 0 holds all state
- i_mem_dato  in  BITS_SIZE  load data from MEM, already size-filtered, valid in the same cycle as the i_exmem_* fields
- i_exmem_alu  in  BITS_SIZE  ALU result
- i_exmem_pc8  in  BITS_SIZE  return address (PC+8) for link instructions
- i_exmem_rd  in  BITS_REG  destination register
- i_exmem_valid  in  1  1 = real instruction, 0 = bubble
- i_exmem_reg_write  in  1  instruction writes the register file
- i_exmem_mem_to_reg  in  1  write-back value comes from memory
- i_exmem_link  in  1  write-back value is PC+8 (JAL/JALR)
- i_exmem_halt  in  1  instruction is HALT
- o_memwb_reg_write  out  1  register-file write enable
- o_memwb_rd  out  BITS_REG  register-file write index
- o_memwb_wb_data  out  BITS_SIZE  register-file write data
- o_halted  out  1  sticky halt flag
- o_retired_count  out  BITS_COUNT  number of valid instructions retired

## Operation
- Reset (i_reset = 0 at a rising edge): all outputs go to 0, counter goes to 0, and o_halted goes to 0. Reset overrides i_step and halt.
- Capture condition: i_reset = 1, i_step = 1, and o_halted = 0. Otherwise every register holds its value.
- On capture:
  - Write-back data priority: if i_exmem_link, use i_exmem_pc8; else if i_exmem_mem_to_reg, use i_mem_dato; else use i_exmem_alu.
  - o_memwb_reg_write is set to i_exmem_valid & i_exmem_reg_write & (i_exmem_rd != 0) & !i_exmem_halt. A write to $zero is never issued.
  - o_memwb_rd is set to i_exmem_rd unconditionally.
  - If i_exmem_valid = 1, o_retired_count increments by 1. The counter saturates at all-ones and does not wrap. Bubbles do not count.
  - If i_exmem_valid & i_exmem_halt, o_halted is set to 1 and the HALT is counted. Once set, o_halted stays 1 until reset.
- While halted:
  - o_memwb_reg_write is forced to 0 on the next edge and held at 0.
  - o_memwb_rd, o_memwb_wb_data and the counter freeze.
  - Further i_step pulses have no effect.
- Two states only: RUN (o_halted = 0) and HALTED (o_halted = 1).
  - RUN to HALTED: on capture of a valid HALT.
  - HALTED to RUN: only on reset.

## Timing
- Latency is 1 cycle: the fields presented at edge N appear on the outputs after edge N.
- All outputs are registered. There is no combinational path from inputs to outputs.
- i_step is a level enable sampled at every edge. A single-cycle i_step pulse advances exactly one instruction.
- Simultaneous reset and capture: reset wins.
- Simultaneous HALT capture: the HALT itself is counted, its write enable is 0, and o_halted is 1 after that same edge.
- Counter at saturation with a valid capture: the value stays at all-ones.

## Test plan
- Reset: hold i_reset = 0 for 2 cycles with random inputs and i_step = 1 → all outputs are 0.
- ALU write-back: valid=1, reg_write=1, rd=5, alu=0x0000_1234, i_step=1 → after one edge, reg_write=1, rd=5, wb_data=0x0000_1234, count=1.
- Select priority: with mem_to_reg=1 and link=1, mem_dato=0xDEAD_BEEF, pc8=0x0000_0040 → wb_data=0x40. Then clear link → wb_data=0xDEAD_BEEF.
- Bubble, $zero and stall:
  - valid=0 → count unchanged and reg_write=0.
  - rd=0 with reg_write=1 → reg_write=0.
  - i_step=0 for 3 cycles with changing inputs → all outputs frozen.
- Halt: retire 3 ALU ops, then a HALT, then 2 more stepped instructions → count=4, o_halted=1, reg_write=0, wb_data equal to the last captured value. Assert reset → o_halted=0 and count=0.
- Saturation (BITS_COUNT=4): step 17 valid instructions → count=0xF.
